scr1_tcm_dport_ctrl: RTL
========================

Name: scr1_tcm_dport_ctrl

Overview:
Data-port controller between the core data-memory interface (dmem req/ack/resp protocol) and port B of the dual-port TCM RAM (renb/wenb/webb/addrb/datab/qb). Converts byte/halfword/word loads and stores into word-addressed RAM accesses with byte enables, aligns read data, flags misaligned and out-of-range accesses, and returns a registered response. The instruction port (port A) is not handled here.

Parameters:
SCR1_WIDTH, 32, data width in bits (only 32 supported)
SCR1_SIZE, 32'h00010000, TCM size in bytes; power of two
SCR1_NBYTES, SCR1_WIDTH/8, byte lanes
AW, $clog2(SCR1_SIZE), byte-address bits decoded

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
dmem_req  in  1  request valid
dmem_cmd  in  1  0=read, 1=write
dmem_width  in  2  0=byte, 1=half, 2=word, 3=reserved (error)
dmem_addr  in  32  byte address (TCM-relative; bits above AW must be 0)
dmem_wdata  in  32  store data, right-justified
dmem_req_ack  out  1  request accepted this cycle
dmem_rdata  out  32  load data, right-shifted by byte offset, upper bits zero
dmem_resp  out  2  0=IDLE, 1=OKAY, 2=ERROR
mem_ren  out  1  to renb
mem_wen  out  1  to wenb
mem_wmask  out  4  to webb
mem_addr  out  AW-2  to addrb (word address)
mem_wdata  out  32  to datab
mem_rdata  in  32  from qb (valid one cycle after mem_ren)

Behaviour:
- Clock clk; reset rst synchronous, active-high; fixed.
- FSM states: IDLE, RD_RESP, WR_RESP, ERR_RESP. Reset -> IDLE; dmem_resp=IDLE, dmem_rdata=0, all registered state cleared.
- dmem_req_ack = dmem_req & (state==IDLE | state==WR_RESP | state==RD_RESP) & ~rst: one request accepted per cycle, back-to-back allowed (throughput 1/cycle); ERR_RESP never accepts (one bubble after error).
- Error check (combinational on accepted request): width==3; half with addr[0]=1; word with addr[1:0]!=0; any of dmem_addr[31:AW] nonzero. On error: no mem_ren/mem_wen, next state ERR_RESP.
- Accepted read: mem_ren=1 same cycle, mem_addr=addr[AW-1:2]; latch offset=addr[1:0], width. Next cycle state RD_RESP: dmem_resp=OKAY, dmem_rdata = mem_rdata >> (8*offset), masked to width (byte: [7:0], half: [15:0], word: full), other bits 0. dmem_rdata combinational from mem_rdata in RD_RESP, 0 otherwise.
- Accepted write: mem_wen=1 same cycle; mem_wmask = byte: 4'b0001<<off; half: 4'b0011<<off; word: 4'b1111. mem_wdata = wdata replicated (byte: {4{wdata[7:0]}}, half: {2{wdata[15:0]}}, word: wdata). Next cycle WR_RESP: dmem_resp=OKAY, dmem_rdata=0.
- ERR_RESP: dmem_resp=ERROR for exactly one cycle, then IDLE (or new accept not possible that cycle).
- No request accepted in a response state -> next state IDLE.
- mem_ren/mem_wen never both 1; both 0 when not accepting. mem_addr/mem_wdata/mem_wmask are don't-care when enables low but driven 0 for determinism.
- Read after write to same word on consecutive cycles: RAM is synchronous, write lands at edge; the following read returns new data — no forwarding needed.
- Reset asserted mid-response: response suppressed next cycle (resp=IDLE), no memory enable during reset cycle.

Decomposition:
- Package scr1_tcm_pkg: typedefs type_scr1_mem_cmd_e, type_scr1_mem_width_e, type_scr1_mem_resp_e, FSM enum type_scr1_tcm_dport_fsm_e, localparam widths. Reuse existing memif package enums if present.
- Optional sub-module scr1_tcm_lane_align: pure combinational store mask/replicate and load shift/mask functions; shared with future port-A alignment logic.

Test Plan:
- Word write addr 0x10 data 0xDEADBEEF -> mem_wen=1, mask 4'b1111, mem_addr=4; next cycle resp OKAY; word read 0x10 -> next cycle rdata 0xDEADBEEF.
- Byte write 0xA5 at 0x13 -> mask 4'b1000, mem_wdata 0xA5A5A5A5; word read 0x10 -> 0xA5ADBEEF; byte read 0x13 -> rdata 0x000000A5.
- Half read 0x12 after above -> 0x0000A5AD; half read 0x11 -> ERROR, no mem_ren, req_ack low the following cycle.
- Address 0x00010000 (SCR1_SIZE) word read -> ERROR; width=3 -> ERROR.
- Back-to-back: write 0x20, read 0x20, read 0x24 on consecutive cycles -> ack each cycle, responses OKAY,OKAY(new data),OKAY in cycles+1.
- Assert rst during RD_RESP -> resp IDLE, rdata 0, state IDLE; first request after deassert served normally.

Source files
------------

// File: rtl/scr1_tcm_pkg.sv
// Shared types for the TCM data-port controller: dmem protocol enums,
// the data-port FSM encoding and the fixed lane geometry.
package scr1_tcm_pkg;

  localparam int unsigned SCR1_TCM_WIDTH  = 32;
  localparam int unsigned SCR1_TCM_NBYTES = SCR1_TCM_WIDTH / 8;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2,
    SCR1_MEM_WIDTH_ERROR = 2'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_TCM_FSM_IDLE     = 2'd0,
    SCR1_TCM_FSM_RD_RESP  = 2'd1,
    SCR1_TCM_FSM_WR_RESP  = 2'd2,
    SCR1_TCM_FSM_ERR_RESP = 2'd3
  } type_scr1_tcm_dport_fsm_e;

endpackage : scr1_tcm_pkg

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane alignment for a 32-bit TCM port: store-side byte enables and
// data replication, load-side right shift and width masking. Purely
// combinational so it can be reused by the instruction-port path.
module scr1_tcm_lane_align
  import scr1_tcm_pkg::*;
(
  input  logic [1:0]  st_width_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_wmask_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_width_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_rdata_o
);

  logic [31:0] ld_shifted;

  // Store path: replicate the right-justified operand across all lanes so the
  // byte enables alone select where it lands.
  always_comb begin
    st_wmask_o = 4'b0000;
    st_wdata_o = 32'h0;
    case (st_width_i)
      SCR1_MEM_WIDTH_BYTE: begin
        st_wmask_o = 4'b0001 << st_offset_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        st_wmask_o = 4'b0011 << st_offset_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: begin
        st_wmask_o = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
      default: begin
        st_wmask_o = 4'b0000;
        st_wdata_o = 32'h0;
      end
    endcase
  end

  assign ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};

  // Load path: bring the addressed lane down to bit 0 and zero the bits above
  // the access width.
  always_comb begin
    ld_rdata_o = 32'h0;
    case (ld_width_i)
      SCR1_MEM_WIDTH_BYTE:  ld_rdata_o = {24'h0, ld_shifted[7:0]};
      SCR1_MEM_WIDTH_HWORD: ld_rdata_o = {16'h0, ld_shifted[15:0]};
      SCR1_MEM_WIDTH_WORD:  ld_rdata_o = ld_shifted;
      default:              ld_rdata_o = 32'h0;
    endcase
  end

endmodule : scr1_tcm_lane_align

// File: rtl/scr1_tcm_dport_ctrl.sv
// TCM data-port controller: accepts dmem requests (one per cycle), drives
// port B of the TCM RAM and returns an OKAY/ERROR response the next cycle.
// Misaligned, reserved-width and out-of-range accesses never touch the RAM.
module scr1_tcm_dport_ctrl
  import scr1_tcm_pkg::*;
#(
  parameter int unsigned SCR1_WIDTH  = 32,
  parameter int unsigned SCR1_SIZE   = 32'h00010000,
  parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
  parameter int unsigned AW          = $clog2(SCR1_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dmem_req,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_width,
  input  logic [31:0]            dmem_addr,
  input  logic [SCR1_WIDTH-1:0]  dmem_wdata,
  output logic                   dmem_req_ack,
  output logic [SCR1_WIDTH-1:0]  dmem_rdata,
  output logic [1:0]             dmem_resp,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [SCR1_NBYTES-1:0] mem_wmask,
  output logic [AW-3:0]          mem_addr,
  output logic [SCR1_WIDTH-1:0]  mem_wdata,
  input  logic [SCR1_WIDTH-1:0]  mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'(SCR1_TCM_FSM_IDLE);
  localparam logic [1:0] ST_RD   = 2'(SCR1_TCM_FSM_RD_RESP);
  localparam logic [1:0] ST_WR   = 2'(SCR1_TCM_FSM_WR_RESP);
  localparam logic [1:0] ST_ERR  = 2'(SCR1_TCM_FSM_ERR_RESP);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ld_offset_q, ld_offset_d;
  logic [1:0]  ld_width_q, ld_width_d;

  logic        accept;
  logic        addr_err;
  logic        rd_go;
  logic        wr_go;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [31:0] ld_rdata;

  // The error state is the only one that refuses a new request, which gives
  // the single bubble after an error; reset also blocks acceptance.
  assign accept       = dmem_req & ~rst & (state_q != ST_ERR);
  assign dmem_req_ack = accept;

  // Access legality: reserved width, natural alignment, and address bits
  // beyond the TCM window.
  always_comb begin
    addr_err = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_HWORD: addr_err = dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:  addr_err = |dmem_addr[1:0];
      SCR1_MEM_WIDTH_ERROR: addr_err = 1'b1;
      default:              addr_err = 1'b0;
    endcase
    if (|dmem_addr[31:AW]) begin
      addr_err = 1'b1;
    end
  end

  assign rd_go = accept & ~addr_err & (dmem_cmd == SCR1_MEM_CMD_RD);
  assign wr_go = accept & ~addr_err & (dmem_cmd == SCR1_MEM_CMD_WR);

  scr1_tcm_lane_align u_lane_align (
    .st_width_i  (dmem_width),
    .st_offset_i (dmem_addr[1:0]),
    .st_wdata_i  (dmem_wdata),
    .st_wmask_o  (st_wmask),
    .st_wdata_o  (st_wdata),
    .ld_width_i  (ld_width_q),
    .ld_offset_i (ld_offset_q),
    .ld_rdata_i  (mem_rdata),
    .ld_rdata_o  (ld_rdata)
  );

  // RAM port B drive; address/data/mask are held at zero when idle so the
  // port does not toggle on unrelated request traffic.
  always_comb begin
    mem_ren   = rd_go;
    mem_wen   = wr_go;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (rd_go || wr_go) begin
      mem_addr = dmem_addr[AW-1:2];
    end
    if (wr_go) begin
      mem_wmask = st_wmask;
      mem_wdata = st_wdata;
    end
  end

  // Next state and captured load alignment; a cycle without an accepted
  // request always returns to IDLE.
  always_comb begin
    state_d     = ST_IDLE;
    ld_offset_d = ld_offset_q;
    ld_width_d  = ld_width_q;
    if (accept) begin
      if (addr_err) begin
        state_d = ST_ERR;
      end else if (dmem_cmd == SCR1_MEM_CMD_WR) begin
        state_d = ST_WR;
      end else begin
        state_d     = ST_RD;
        ld_offset_d = dmem_addr[1:0];
        ld_width_d  = dmem_width;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_offset_q <= 2'b00;
      ld_width_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      ld_offset_q <= ld_offset_d;
      ld_width_q  <= ld_width_d;
    end
  end

  // Response decode; a reset arriving during a response state silences that
  // response immediately rather than letting it leak out for a cycle.
  always_comb begin
    dmem_resp  = SCR1_MEM_RESP_IDLE;
    dmem_rdata = '0;
    if (!rst) begin
      case (state_q)
        ST_RD: begin
          dmem_resp  = SCR1_MEM_RESP_RDY_OK;
          dmem_rdata = ld_rdata;
        end
        ST_WR:   dmem_resp = SCR1_MEM_RESP_RDY_OK;
        ST_ERR:  dmem_resp = SCR1_MEM_RESP_RDY_ER;
        default: dmem_resp = SCR1_MEM_RESP_IDLE;
      endcase
    end
  end

endmodule : scr1_tcm_dport_ctrl
